// File: rtl/demux4x32_reg.sv
// Registered 1-to-4 word demultiplexer: one holding register with valid/ready per channel.
// Define DEMUX4X32_STAT_EN to add per-channel saturating transfer counters (cnt_sel/cnt ports).
module demux4x32_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3
`ifdef DEMUX4X32_STAT_EN
  ,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_chk
    $error("WIDTH and CNT_W must both be at least 1");
  end

  logic [WIDTH-1:0] r_y [4];
  logic [3:0]       r_v;
  logic [3:0]       w_rdy;
  logic [3:0]       w_acc;

  assign w_rdy    = {r3, r2, r1, r0};
  // Readiness looks only at the selected channel, so a stalled channel never blocks the others.
  assign in_ready = ~r_v[s] | w_rdy[s];
  assign w_acc    = (in_valid && in_ready) ? (4'b0001 << s) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc[i]) begin
          r_y[i] <= d;
          r_v[i] <= 1'b1;
        end else if (w_rdy[i]) begin
          r_v[i] <= 1'b0;
        end
      end
    end
  end

  assign y0 = r_y[0];
  assign y1 = r_y[1];
  assign y2 = r_y[2];
  assign y3 = r_y[3];
  assign v0 = r_v[0];
  assign v1 = r_v[1];
  assign v2 = r_v[2];
  assign v3 = r_v[3];

`ifdef DEMUX4X32_STAT_EN
  logic [CNT_W-1:0] r_cnt [4];

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign cnt = r_cnt[cnt_sel];
`endif

endmodule
